// File: rtl/aes_128_sub_bytes.sv
// AES SubBytes engine: streams the 16 state bytes through a dual-port S-box
// table two at a time and reassembles the substituted state.
module aes_128_sub_bytes #(
    parameter int SBOX_LAT = 1
) (
    input  logic         clk,
    input  logic         kill_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [7:0]   sbox_addra,
    output logic [7:0]   sbox_addrb,
    input  logic [7:0]   sbox_doa,
    input  logic [7:0]   sbox_dob,
    output logic         sbox_wea,
    output logic         sbox_web,
    output logic [7:0]   sbox_dia,
    output logic [7:0]   sbox_dib,
    output logic         sbox_kill
);

    typedef enum logic [1:0] {IDLE, LOOKUP, DRAIN, DONE} state_t;

    state_t                      state, state_nxt;
    logic [127:0]                st_q, res_q, st_sh;
    logic [2:0]                  cnt;
    logic [1:0]                  drain_cnt;
    logic [SBOX_LAT-1:0]         vld_pipe;
    logic [SBOX_LAT-1:0][2:0]    idx_pipe;
    logic                        issue;

    assign issue     = (state == LOOKUP);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_state = res_q;

    // The table is read-only from this block.
    assign sbox_wea  = 1'b0;
    assign sbox_web  = 1'b0;
    assign sbox_dia  = 8'h00;
    assign sbox_dib  = 8'h00;
    assign sbox_kill = ~kill_n;

    // Shift the state so byte pair cnt lands in the top 16 bits.
    assign st_sh = st_q << {cnt, 4'b0000};

    always_comb begin
        state_nxt  = state;
        sbox_addra = 8'h00;
        sbox_addrb = 8'h00;
        case (state)
            IDLE:   if (in_valid) state_nxt = LOOKUP;
            LOOKUP: begin
                sbox_addra = st_sh[127:120];
                sbox_addrb = st_sh[119:112];
                if (cnt == 3'd7) state_nxt = DRAIN;
            end
            DRAIN:  if (drain_cnt == 2'(SBOX_LAT - 1)) state_nxt = DONE;
            DONE:   if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!kill_n) begin
            state     <= IDLE;
            st_q      <= '0;
            res_q     <= '0;
            cnt       <= '0;
            drain_cnt <= '0;
            vld_pipe  <= '0;
            idx_pipe  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                st_q <= in_state;
                cnt  <= '0;
            end else if (state == LOOKUP) begin
                cnt <= cnt + 3'd1;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;

            // Tag each issued pair so its read data is placed when it returns.
            vld_pipe[0] <= issue;
            idx_pipe[0] <= cnt;
            for (int s = 1; s < SBOX_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end

            if (vld_pipe[SBOX_LAT-1]) begin
                for (int i = 0; i < 8; i++) begin
                    if (idx_pipe[SBOX_LAT-1] == i[2:0]) begin
                        res_q[127-16*i -: 8] <= sbox_doa;
                        res_q[119-16*i -: 8] <= sbox_dob;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_128_sub_bytes.sv
// Directed bench for aes_128_sub_bytes with a behavioural dual-port S-box
// table; one instance at read latency 1, one at latency 2 (inverse table).
module tb_aes_128_sub_bytes;

    logic         clk = 1'b0;
    logic         kill_n;
    logic         iv1, iv2, ordy1, ordy2;
    logic [127:0] din;
    logic         ir1, ov1, ir2, ov2;
    logic [127:0] os1, os2;
    logic [7:0]   aa1, ab1, aa2, ab2, da1, db1, da2, db2;
    logic         wea1, web1, wea2, web2, k1, k2;
    logic [7:0]   dia1, dib1, dia2, dib2;

    int n_chk = 0;
    int n_err = 0;
    bit dec   = 1'b0;

    logic [7:0]   fwd [256];
    logic [7:0]   inv [256];
    logic [127:0] rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] V_PT = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V_CT = 128'h637c777bf26b6fc53001672bfed7ab76;

    always #5 clk = ~clk;

    aes_128_sub_bytes #(.SBOX_LAT(1)) u_dut1 (
        .clk(clk), .kill_n(kill_n), .in_valid(iv1), .in_ready(ir1), .in_state(din),
        .out_valid(ov1), .out_ready(ordy1), .out_state(os1),
        .sbox_addra(aa1), .sbox_addrb(ab1), .sbox_doa(da1), .sbox_dob(db1),
        .sbox_wea(wea1), .sbox_web(web1), .sbox_dia(dia1), .sbox_dib(dib1),
        .sbox_kill(k1));

    aes_128_sub_bytes #(.SBOX_LAT(2)) u_dut2 (
        .clk(clk), .kill_n(kill_n), .in_valid(iv2), .in_ready(ir2), .in_state(din),
        .out_valid(ov2), .out_ready(ordy2), .out_state(os2),
        .sbox_addra(aa2), .sbox_addrb(ab2), .sbox_doa(da2), .sbox_dob(db2),
        .sbox_wea(wea2), .sbox_web(web2), .sbox_dia(dia2), .sbox_dib(dib2),
        .sbox_kill(k2));

    // Table models: latency 1 (forward or inverse by dec) and latency 2 (inverse).
    logic [7:0] p2a, p2b;
    always @(posedge clk) begin
        if (k1) begin
            da1 <= 8'h00; db1 <= 8'h00;
        end else begin
            da1 <= dec ? inv[aa1] : fwd[aa1];
            db1 <= dec ? inv[ab1] : fwd[ab1];
        end
        if (k2) begin
            p2a <= 8'h00; p2b <= 8'h00; da2 <= 8'h00; db2 <= 8'h00;
        end else begin
            p2a <= inv[aa2]; p2b <= inv[ab2];
            da2 <= p2a;      db2 <= p2b;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start(input bit sel, input logic [127:0] d);
        din = d;
        if (sel) iv2 = 1'b1; else iv1 = 1'b1;
        chk("accept_ready", {127'd0, sel ? ir2 : ir1}, 128'd1);
        tick();
        iv1 = 1'b0; iv2 = 1'b0;
    endtask

    // Returns the number of edges after the accept edge until out_valid rises.
    task automatic wait_done(input bit sel, output int n);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (sel ? ov2 : ov1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic release_out(input bit sel);
        if (sel) ordy2 = 1'b1; else ordy1 = 1'b1;
        tick();
        ordy1 = 1'b0; ordy2 = 1'b0;
        chk("post_ready", {127'd0, sel ? ir2 : ir1}, 128'd1);
        chk("post_valid", {127'd0, sel ? ov2 : ov1}, 128'd0);
    endtask

    task automatic run(input bit sel, input logic [127:0] d, input int lat,
                       input logic [127:0] exp, input string tag);
        int n;
        start(sel, d);
        wait_done(sel, n);
        chk({tag, "_lat"}, 128'(n), 128'(lat));
        chk({tag, "_data"}, sel ? os2 : os1, exp);
        release_out(sel);
    endtask

    initial begin
        int n;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                fwd[r*16+c] = rows[r][127-8*c -: 8];
        for (int i = 0; i < 256; i++) inv[fwd[i]] = 8'(i);

        kill_n = 1'b0; iv1 = 1'b0; iv2 = 1'b0; ordy1 = 1'b0; ordy2 = 1'b0; din = '0;
        tick(); tick();
        chk("rst_sbox_kill", {127'd0, k1}, 128'd1);
        kill_n = 1'b1;
        tick();
        chk("rst_in_ready", {127'd0, ir1}, 128'd1);
        chk("rst_out_valid", {127'd0, ov1}, 128'd0);
        chk("rst_out_state", os1, 128'd0);
        chk("rst_addr", {112'd0, aa1, ab1}, 128'd0);

        // 1) FIPS-197 style byte ramp.
        run(1'b0, V_PT, 9, V_CT, "vec1");

        // 2) Same byte on both ports every cycle; out_ready high while idle/busy.
        ordy1 = 1'b1;
        tick();
        chk("idle_ready_noeffect", {127'd0, ov1}, 128'd0);
        ordy1 = 1'b0;
        start(1'b0, {16{8'h53}});
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("dup_addr%0d", k), {112'd0, aa1, ab1}, {112'd0, 16'h5353});
            tick();
        end
        chk("drain_addr", {112'd0, aa1, ab1}, 128'd0);
        tick();
        chk("dup_valid", {127'd0, ov1}, 128'd1);
        chk("dup_data", os1, {16{8'hed}});

        // 3) Backpressure in DONE, with in_valid asserted (must be ignored).
        iv1 = 1'b1; din = V_PT;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", {127'd0, ov1}, 128'd1);
            chk("bp_data", os1, {16{8'hed}});
            chk("bp_ready", {127'd0, ir1}, 128'd0);
        end
        iv1 = 1'b0;
        release_out(1'b0);

        // 4) Kill mid-LOOKUP at cnt=4, then a clean retry.
        start(1'b0, V_PT);
        for (int k = 0; k < 4; k++) tick();
        kill_n = 1'b0;
        tick();
        kill_n = 1'b1;
        chk("kill_valid", {127'd0, ov1}, 128'd0);
        chk("kill_ready", {127'd0, ir1}, 128'd1);
        chk("kill_state", os1, 128'd0);
        tick(); tick();
        chk("kill_stays_idle", {127'd0, ov1, ir1}, 128'd1);
        run(1'b0, V_PT, 9, V_CT, "retry");

        // 5) Descending bytes: address order and quiet write side.
        start(1'b0, 128'h0f0e0d0c0b0a09080706050403020100);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ord_addr%0d", k), {112'd0, aa1, ab1},
                {112'd0, 8'(8'h0f - 2*k), 8'(8'h0e - 2*k)});
            chk("ord_wr_quiet", {108'd0, wea1, web1, dia1, dib1}, 128'd0);
            tick();
        end
        wait_done(1'b0, n);
        chk("ord_data", os1, 128'h76abd7fe2b670130c56f6bf27b777c63);
        release_out(1'b0);

        // 6) Inverse table, latency 1 then latency 2.
        dec = 1'b1;
        run(1'b0, V_CT, 9, V_PT, "dec_l1");
        run(1'b1, V_CT, 10, V_PT, "dec_l2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
